twos_comp_seq: RTL

- Sequencer for the bit-serial two's-complement datapath.
- Accepts an operand over a valid/ready handshake and generates the one-hot timing pulse vector T that steps the ones'-complement stage.
- Performs the serial +1 carry chain one bit per pulse, then presents the result with status flags over a valid/ready output handshake.
- Sits between the operand source and downstream arithmetic; one operation in flight at a time.

---
 rtl/twos_comp_pkg.sv | 19 +
 rtl/twos_comp_bitcell.sv | 15 +
 rtl/twos_comp_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/twos_comp_pkg.sv
// Shared types and helpers for the bit-serial two's-complement sequencer.
// Holds the FSM encoding, the default width and the pulse-index mapping.
package twos_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int N_BITS = 8;

    // T[0] marks the load cycle; T[k] marks the step that processes bit k-1.
    function automatic int unsigned pulse_index(input logic is_load, input int unsigned step);
        return is_load ? 32'd0 : step + 32'd1;
    endfunction

endpackage

// File: rtl/twos_comp_bitcell.sv
// One serial step of the two's-complement chain: invert the operand bit,
// then add the running +1 carry.
module twos_comp_bitcell (
    input  logic b,
    input  logic carry_in,
    output logic bbar,
    output logic sum,
    output logic carry_out
);

    assign bbar      = ~b;
    assign sum       = bbar ^ carry_in;
    assign carry_out = bbar & carry_in;

endmodule

// File: rtl/twos_comp_seq.sv
// Sequencer for the bit-serial two's-complement datapath: accepts an operand,
// walks one-hot timing pulses through the +1 chain and hands back the result.
module twos_comp_seq
    import twos_comp_pkg::*;
#(
    parameter int n_bits = N_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [n_bits-1:0] B,
    output logic [n_bits:0]   T,
    output logic [n_bits-1:0] Bbar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [n_bits-1:0] result,
    output logic              carry_out,
    output logic              ovf,
    output logic              busy
);

    localparam int pulses = n_bits + 1;
    localparam int IDX_W  = $clog2(n_bits);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(n_bits - 1);
    localparam logic [n_bits-1:0] MOST_NEG = {1'b1, {(n_bits-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [pulses-1:0] t_reg, t_next;
    logic [n_bits-1:0] breg_reg;
    logic [n_bits-1:0] bbar_reg;
    logic [n_bits-1:0] result_reg;
    logic              carry_reg;
    logic              carry_out_reg;
    logic              ovf_reg;

    logic cell_bbar, cell_sum, cell_carry;

    twos_comp_bitcell u_bitcell (
        .b         (breg_reg[idx_reg]),
        .carry_in  (carry_reg),
        .bbar      (cell_bbar),
        .sum       (cell_sum),
        .carry_out (cell_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            t_reg     <= t_next;
        end
    end

    // T is registered from the next state so the pulse lines up with the state it marks.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        t_next     = '0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: state_next = COMP;
            COMP: begin
                if (idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            LOAD:    t_next = pulses'(1) << pulse_index(1'b1, 32'd0);
            COMP:    t_next = pulses'(1) << pulse_index(1'b0, 32'(idx_next));
            default: t_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            breg_reg      <= '0;
            bbar_reg      <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        breg_reg  <= B;
                        carry_reg <= 1'b1;
                    end
                end
                COMP: begin
                    bbar_reg[idx_reg]   <= cell_bbar;
                    result_reg[idx_reg] <= cell_sum;
                    carry_reg           <= cell_carry;
                    if (idx_reg == IDX_LAST) begin
                        carry_out_reg <= cell_carry;
                        ovf_reg       <= (breg_reg == MOST_NEG);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign T         = t_reg;
    assign Bbar      = bbar_reg;
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign ovf       = ovf_reg;

endmodule
